// File: rtl/ucode_sequencer.sv
// ---------------------------------------------------------------------------
// ucode_sequencer
//
// Microcode expansion stage that sits directly after instruction fetch.
// Ordinary instructions pass through a one-cycle register. A macro-op
// (opcode UCODE_OP in in_instr[31:25]) freezes fetch through `control`.
// The stage then issues micro-instructions from an internal writable ROM,
// starting at in_instr[UADDR_W-1:0]. A sequence ends on an entry with its
// last flag set, or is cut off after MAX_LEN micro-ops (sticky err_overrun).
// A single RESUME cycle follows each sequence. It swallows the stale repeat
// of the macro-op that fetch presents while it is being released.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   in_instr     : instruction from fetch
//   in_valid     : in_instr is meaningful
//   stall        : downstream hold; freezes state and registered outputs
//   ucode_we     : ROM write enable (honoured in any state, even under stall)
//   ucode_waddr  : ROM write address
//   ucode_wdata  : ROM entry, bit 32 = last flag, bits 31:0 = micro-op
//   control      : fetch freeze request (combinational)
//   out_instr    : issued instruction (registered)
//   out_valid    : out_instr is valid (registered)
//   out_ucode    : issued instruction came from the ROM (registered)
//   upc          : current micro-PC
//   err_overrun  : sticky, a sequence reached MAX_LEN without a last flag
// ---------------------------------------------------------------------------
module ucode_sequencer #(
  parameter int         UADDR_W  = 6,
  parameter logic [6:0] UCODE_OP = 7'b1110000,
  parameter int         MAX_LEN  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        in_instr,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               ucode_we,
  input  logic [UADDR_W-1:0] ucode_waddr,
  input  logic [32:0]        ucode_wdata,
  output logic               control,
  output logic [31:0]        out_instr,
  output logic               out_valid,
  output logic               out_ucode,
  output logic [UADDR_W-1:0] upc,
  output logic               err_overrun
);

  localparam int ROM_DEPTH = 2 ** UADDR_W;
  localparam int CNT_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESUME = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [UADDR_W-1:0] r_upc;
  logic [UADDR_W-1:0] w_upcNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [31:0]        r_outInstr;
  logic [31:0]        w_outInstrNext;
  logic               r_outValid;
  logic               w_outValidNext;
  logic               r_outUcode;
  logic               w_outUcodeNext;
  logic               r_errOverrun;
  logic               w_errOverrunNext;
  logic               w_control;
  logic               w_macro;
  logic [32:0]        w_romEntry;

  logic [32:0] r_rom [ROM_DEPTH];

  // ROM contents survive reset; the write lands at the edge, so a read of the
  // same address in the same cycle still sees the old entry.
  always_ff @(posedge clk) begin
    if (ucode_we) begin
      r_rom[ucode_waddr] <= ucode_wdata;
    end
  end

  assign w_romEntry = r_rom[r_upc];
  assign w_macro    = in_valid && (in_instr[31:25] == UCODE_OP);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Datapath registers; every next value comes from the combinational block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upc        <= '0;
      r_cnt        <= '0;
      r_outInstr   <= '0;
      r_outValid   <= 1'b0;
      r_outUcode   <= 1'b0;
      r_errOverrun <= 1'b0;
    end else begin
      r_upc        <= w_upcNext;
      r_cnt        <= w_cntNext;
      r_outInstr   <= w_outInstrNext;
      r_outValid   <= w_outValidNext;
      r_outUcode   <= w_outUcodeNext;
      r_errOverrun <= w_errOverrunNext;
    end
  end

  // Next-state and output logic. Everything holds by default, which also
  // covers stall. control ignores stall so fetch stays frozen throughout.
  always_comb begin
    w_stateNext      = r_state;
    w_upcNext        = r_upc;
    w_cntNext        = r_cnt;
    w_outInstrNext   = r_outInstr;
    w_outValidNext   = r_outValid;
    w_outUcodeNext   = r_outUcode;
    w_errOverrunNext = r_errOverrun;
    w_control        = 1'b0;

    case (r_state)
      IDLE: begin
        w_control = w_macro;
        if (!stall) begin
          if (w_macro) begin
            // The macro-op itself is never issued downstream.
            w_upcNext      = in_instr[UADDR_W-1:0];
            w_cntNext      = '0;
            w_outValidNext = 1'b0;
            w_stateNext    = RUN;
          end else begin
            w_outInstrNext = in_instr;
            w_outValidNext = in_valid;
            w_outUcodeNext = 1'b0;
          end
        end
      end

      RUN: begin
        w_control = 1'b1;
        if (!stall) begin
          w_outInstrNext = w_romEntry[31:0];
          w_outValidNext = 1'b1;
          w_outUcodeNext = 1'b1;
          if (w_romEntry[32]) begin
            w_stateNext = RESUME;
          end else if (r_cnt == CNT_W'(MAX_LEN - 1)) begin
            w_errOverrunNext = 1'b1;
            w_stateNext      = RESUME;
          end else begin
            w_upcNext = r_upc + UADDR_W'(1);
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end
      end

      RESUME: begin
        // Fetch re-presents the frozen macro-op here; it is deliberately dropped.
        if (!stall) begin
          w_outValidNext = 1'b0;
          w_outUcodeNext = 1'b0;
          w_stateNext    = IDLE;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign control     = w_control;
  assign out_instr   = r_outInstr;
  assign out_valid   = r_outValid;
  assign out_ucode   = r_outUcode;
  assign upc         = r_upc;
  assign err_overrun = r_errOverrun;

endmodule
